sdp_rr_arbiter: RTL and testbench

- Shares one sdp_one_clk simple-dual-port RAM between NREQ requesters.
- Write port and read port are arbitrated independently, each with a round-robin scheduler.
- Drives the RAM command pins and routes RAM read data back to the requester that issued the read, tagged by a one-hot valid.
- Optionally forwards write data on a same-cycle read/write address collision, so requesters see write-first data whatever collision mode the RAM uses.

---
 rtl/sdp_arb_pkg.sv | 18 +
 rtl/sdp_rr_sched.sv | 49 ++++
 rtl/sdp_rr_arbiter.sv | 104 ++++++++++
 tb/tb_sdp_rr_arbiter.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/sdp_arb_pkg.sv
// Shared types and helpers for the simple-dual-port RAM arbiter.
package sdp_arb_pkg;

  localparam int NREQ_MAX = 4;

  function automatic int clog2(input int n);
    int r;
    r = 1;
    for (int i = 1; i < 32; i++) begin
      if ((1 << i) < n) r = i + 1;
    end
    return r;
  endfunction

  typedef logic [NREQ_MAX-1:0]        gnt_vec_t;
  typedef logic [clog2(NREQ_MAX)-1:0] ptr_t;

endpackage

// File: rtl/sdp_rr_sched.sv
// Round-robin scheduler: pointer register plus masked priority select.
module rr_sched
  import sdp_arb_pkg::*;
#(
  parameter int NREQ = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [NREQ-1:0] req,
  output logic [NREQ-1:0] gnt
);

  localparam int PW = clog2(NREQ);

  logic [PW-1:0] ptr_q, ptr_d;
  logic [PW-1:0] lo_idx, hi_idx, sel_idx;
  logic          hit_any, hit_hi;

  // Lowest request at or above ptr wins; otherwise the lowest request overall.
  always_comb begin
    lo_idx  = '0;
    hi_idx  = '0;
    hit_any = 1'b0;
    hit_hi  = 1'b0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      if (req[k]) begin
        hit_any = 1'b1;
        lo_idx  = PW'(k);
        if (k >= int'(ptr_q)) begin
          hit_hi = 1'b1;
          hi_idx = PW'(k);
        end
      end
    end
    sel_idx = hit_hi ? hi_idx : lo_idx;
    gnt     = '0;
    ptr_d   = ptr_q;
    if (hit_any && !rst) begin
      gnt[sel_idx] = 1'b1;
      ptr_d        = (sel_idx == PW'(NREQ - 1)) ? '0 : sel_idx + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) ptr_q <= '0;
    else     ptr_q <= ptr_d;
  end

endmodule

// File: rtl/sdp_rr_arbiter.sv
// Arbitrates NREQ requesters onto one simple-dual-port RAM and routes read
// data back with a one-hot valid, optionally forwarding colliding writes.
module sdp_rr_arbiter
  import sdp_arb_pkg::*;
#(
  parameter int AW     = 4,
  parameter int DW     = 4,
  parameter int NREQ   = 2,
  parameter int FWD_EN = 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NREQ-1:0]    wr_req,
  input  logic [NREQ*AW-1:0] wr_addr,
  input  logic [NREQ*DW-1:0] wr_data,
  output logic [NREQ-1:0]    wr_gnt,
  input  logic [NREQ-1:0]    rd_req,
  input  logic [NREQ*AW-1:0] rd_addr,
  output logic [NREQ-1:0]    rd_gnt,
  output logic [NREQ-1:0]    rd_vld,
  output logic [DW-1:0]      rd_data,
  output logic               wen,
  output logic [AW-1:0]      waddr,
  output logic [DW-1:0]      din,
  output logic               ren,
  output logic [AW-1:0]      raddr,
  input  logic [DW-1:0]      dout
);

  logic              wen_q, ren_q;
  logic [AW-1:0]     waddr_q, waddr_d, raddr_q, raddr_d;
  logic [DW-1:0]     din_q, din_d;
  logic [NREQ-1:0]   tag_p1_q, tag_p2_q;
  logic              byp_vld_q, collide;
  logic [DW-1:0]     byp_q;

  rr_sched #(.NREQ(NREQ)) u_wr_sched (
    .clk (clk),
    .rst (rst),
    .req (wr_req),
    .gnt (wr_gnt)
  );

  rr_sched #(.NREQ(NREQ)) u_rd_sched (
    .clk (clk),
    .rst (rst),
    .req (rd_req),
    .gnt (rd_gnt)
  );

  // Grant stage: select the granted requester's fields; hold when idle.
  always_comb begin
    waddr_d = waddr_q;
    din_d   = din_q;
    raddr_d = raddr_q;
    for (int i = 0; i < NREQ; i++) begin
      if (wr_gnt[i]) begin
        waddr_d = wr_addr[i*AW +: AW];
        din_d   = wr_data[i*DW +: DW];
      end
      if (rd_gnt[i]) raddr_d = rd_addr[i*AW +: AW];
    end
  end

  assign collide = (FWD_EN != 0) && wen_q && ren_q && (waddr_q == raddr_q);

  // Command stage: RAM pins, first tag stage and collision capture.
  always_ff @(posedge clk) begin
    if (rst) begin
      wen_q     <= 1'b0;
      ren_q     <= 1'b0;
      waddr_q   <= '0;
      raddr_q   <= '0;
      din_q     <= '0;
      tag_p1_q  <= '0;
      tag_p2_q  <= '0;
      byp_vld_q <= 1'b0;
    end else begin
      wen_q     <= |wr_gnt;
      ren_q     <= |rd_gnt;
      waddr_q   <= waddr_d;
      raddr_q   <= raddr_d;
      din_q     <= din_d;
      tag_p1_q  <= rd_gnt;
      tag_p2_q  <= tag_p1_q;
      byp_vld_q <= collide;
    end
  end

  always_ff @(posedge clk) begin
    if (collide) byp_q <= din_q;
  end

  // Response stage: RAM data, or the forwarded write when the read collided.
  assign rd_vld  = tag_p2_q;
  assign rd_data = (|tag_p2_q) ? (byp_vld_q ? byp_q : dout) : '0;

  assign wen   = wen_q;
  assign ren   = ren_q;
  assign waddr = waddr_q;
  assign raddr = raddr_q;
  assign din   = din_q;

endmodule

// File: tb/tb_sdp_rr_arbiter.sv
// Bench for sdp_rr_arbiter: a 2-requester forwarding instance and a
// 3-requester raw instance, each on a small RAM, checked against a model.
module tb_sdp_rr_arbiter;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [1:0] wr_req0, wr_gnt0, rd_req0, rd_gnt0, rd_vld0;
  logic [7:0] wr_addr0, wr_data0, rd_addr0;
  logic [3:0] rd_data0, waddr0, din0, raddr0, dout0;
  logic       wen0, ren0;

  logic [2:0]  wr_req1, wr_gnt1, rd_req1, rd_gnt1, rd_vld1;
  logic [11:0] wr_addr1, wr_data1, rd_addr1;
  logic [3:0]  rd_data1, waddr1, din1, raddr1, dout1;
  logic        wen1, ren1;

  sdp_rr_arbiter #(.AW(4), .DW(4), .NREQ(2), .FWD_EN(1)) dut (
    .clk(clk), .rst(rst),
    .wr_req(wr_req0), .wr_addr(wr_addr0), .wr_data(wr_data0), .wr_gnt(wr_gnt0),
    .rd_req(rd_req0), .rd_addr(rd_addr0), .rd_gnt(rd_gnt0),
    .rd_vld(rd_vld0), .rd_data(rd_data0),
    .wen(wen0), .waddr(waddr0), .din(din0), .ren(ren0), .raddr(raddr0), .dout(dout0)
  );

  sdp_rr_arbiter #(.AW(4), .DW(4), .NREQ(3), .FWD_EN(0)) dut3 (
    .clk(clk), .rst(rst),
    .wr_req(wr_req1), .wr_addr(wr_addr1), .wr_data(wr_data1), .wr_gnt(wr_gnt1),
    .rd_req(rd_req1), .rd_addr(rd_addr1), .rd_gnt(rd_gnt1),
    .rd_vld(rd_vld1), .rd_data(rd_data1),
    .wen(wen1), .waddr(waddr1), .din(din1), .ren(ren1), .raddr(raddr1), .dout(dout1)
  );

  // RAMs: read returns old contents on a same-address collision; cleared by rst.
  logic [3:0] mem0 [16];
  logic [3:0] mem1 [16];
  always @(posedge clk) begin
    if (rst) begin
      for (int a = 0; a < 16; a++) mem0[a] <= 4'h0;
    end else begin
      if (ren0) dout0 <= mem0[raddr0];
      if (wen0) mem0[waddr0] <= din0;
    end
  end
  always @(posedge clk) begin
    if (rst) begin
      for (int a = 0; a < 16; a++) mem1[a] <= 4'h0;
    end else begin
      if (ren1) dout1 <= mem1[raddr1];
      if (wen1) mem1[waddr1] <= din1;
    end
  end

  // Requester state and reference model, index [instance][requester].
  logic       wq [2][4], rq [2][4];
  logic [3:0] wa [2][4], wd [2][4], ra [2][4];
  logic [3:0] sh [2][16];
  int         wptr [2], rptr [2];
  logic [3:0] ev [2][4096], ed [2][4096];
  logic       ew [2][4096], er [2][4096];
  logic [3:0] ewa [2][4096], ewd [2][4096], era [2][4096];
  logic [3:0] s_wg [2], s_rg [2], s_vl [2], s_rd [2];
  int         cyc, n_cmp, n_bad;
  bit         hold;

  task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_bad++;
      $error("FAIL %s (cycle %0d): observed %h expected %h", tag, cyc, obs, exp);
    end
  endtask

  task automatic drive();
    for (int i = 0; i < 2; i++) begin
      wr_req0[i] = wq[0][i]; rd_req0[i] = rq[0][i];
      wr_addr0[i*4 +: 4] = wa[0][i]; wr_data0[i*4 +: 4] = wd[0][i];
      rd_addr0[i*4 +: 4] = ra[0][i];
    end
    for (int i = 0; i < 3; i++) begin
      wr_req1[i] = wq[1][i]; rd_req1[i] = rq[1][i];
      wr_addr1[i*4 +: 4] = wa[1][i]; wr_data1[i*4 +: 4] = wd[1][i];
      rd_addr1[i*4 +: 4] = ra[1][i];
    end
  endtask

  task automatic model_cycle(input int d);
    int n, wi, ri, j;
    logic [3:0] o_wg, o_rg, o_vl, o_rd, o_wa, o_din, o_ra, v;
    logic o_wen, o_ren;
    string p;
    p = (d == 0) ? "n2" : "n3";
    n = (d == 0) ? 2 : 3;
    if (d == 0) begin
      o_wg = {2'b00, wr_gnt0}; o_rg = {2'b00, rd_gnt0}; o_vl = {2'b00, rd_vld0};
      o_rd = rd_data0; o_wen = wen0; o_ren = ren0;
      o_wa = waddr0; o_din = din0; o_ra = raddr0;
    end else begin
      o_wg = {1'b0, wr_gnt1}; o_rg = {1'b0, rd_gnt1}; o_vl = {1'b0, rd_vld1};
      o_rd = rd_data1; o_wen = wen1; o_ren = ren1;
      o_wa = waddr1; o_din = din1; o_ra = raddr1;
    end
    s_wg[d] = o_wg; s_rg[d] = o_rg; s_vl[d] = o_vl; s_rd[d] = o_rd;
    wi = -1; ri = -1;
    if (!rst) begin
      for (int k = 0; k < n; k++) begin
        j = (wptr[d] + k) % n;
        if (wi < 0 && wq[d][j]) wi = j;
        j = (rptr[d] + k) % n;
        if (ri < 0 && rq[d][j]) ri = j;
      end
    end
    chk({p, " wr_gnt"}, o_wg, (wi >= 0) ? 4'(1 << wi) : 4'h0);
    chk({p, " rd_gnt"}, o_rg, (ri >= 0) ? 4'(1 << ri) : 4'h0);
    chk({p, " rd_vld"}, o_vl, ev[d][cyc]);
    if (ev[d][cyc] != 4'h0) chk({p, " rd_data"}, o_rd, ed[d][cyc]);
    chk({p, " wen"}, {3'b0, o_wen}, {3'b0, ew[d][cyc]});
    if (ew[d][cyc]) begin
      chk({p, " waddr"}, o_wa, ewa[d][cyc]);
      chk({p, " din"}, o_din, ewd[d][cyc]);
    end
    chk({p, " ren"}, {3'b0, o_ren}, {3'b0, er[d][cyc]});
    if (er[d][cyc]) chk({p, " raddr"}, o_ra, era[d][cyc]);
    if (rst) begin
      wptr[d] = 0; rptr[d] = 0;
      ev[d][cyc+1] = 4'h0; ev[d][cyc+2] = 4'h0;
      ew[d][cyc+1] = 1'b0; er[d][cyc+1] = 1'b0;
      for (int a = 0; a < 16; a++) sh[d][a] = 4'h0;
    end else begin
      ew[d][cyc+1] = (wi >= 0);
      er[d][cyc+1] = (ri >= 0);
      ev[d][cyc+2] = (ri >= 0) ? 4'(1 << ri) : 4'h0;
      // Forwarding instance sees the same-cycle write; the raw one sees old data.
      if (ri >= 0 && d == 1) ed[d][cyc+2] = sh[d][ra[d][ri]];
      if (wi >= 0) begin
        ewa[d][cyc+1] = wa[d][wi]; ewd[d][cyc+1] = wd[d][wi];
        sh[d][wa[d][wi]] = wd[d][wi];
        wptr[d] = (wi + 1) % n;
        if (!hold) wq[d][wi] = 1'b0;
      end
      if (ri >= 0) begin
        v = sh[d][ra[d][ri]];
        if (d == 0) ed[d][cyc+2] = v;
        era[d][cyc+1] = ra[d][ri];
        rptr[d] = (ri + 1) % n;
        if (!hold) rq[d][ri] = 1'b0;
      end
    end
  endtask

  task automatic tick();
    drive();
    @(negedge clk);
    model_cycle(0);
    model_cycle(1);
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic set_wr(input int d, input int i, input logic [3:0] a, input logic [3:0] v);
    wq[d][i] = 1'b1; wa[d][i] = a; wd[d][i] = v;
  endtask

  task automatic set_rd(input int d, input int i, input logic [3:0] a);
    rq[d][i] = 1'b1; ra[d][i] = a;
  endtask

  task automatic clr_all();
    for (int d = 0; d < 2; d++)
      for (int i = 0; i < 4; i++) begin
        wq[d][i] = 1'b0; rq[d][i] = 1'b0;
      end
  endtask

  initial begin
    cyc = 0; n_cmp = 0; n_bad = 0; hold = 1'b0; rst = 1'b1;
    for (int d = 0; d < 2; d++) begin
      wptr[d] = 0; rptr[d] = 0;
      for (int i = 0; i < 4; i++) begin
        wq[d][i] = 1'b0; rq[d][i] = 1'b0; wa[d][i] = 4'h0; wd[d][i] = 4'h0; ra[d][i] = 4'h0;
      end
      for (int a = 0; a < 16; a++) sh[d][a] = 4'h0;
      for (int c = 0; c < 4096; c++) begin
        ev[d][c] = 4'h0; ed[d][c] = 4'h0; ew[d][c] = 1'b0; er[d][c] = 1'b0;
        ewa[d][c] = 4'h0; ewd[d][c] = 4'h0; era[d][c] = 4'h0;
      end
    end
    drive();
    @(posedge clk);
    #1;

    // Reset state, then idle.
    tick();
    chk("rst waddr", waddr0, 4'h0);
    chk("rst raddr", raddr0, 4'h0);
    chk("rst din", din0, 4'h0);
    chk("rst rd_data", rd_data0, 4'h0);
    chk("rst rd_data n3", rd_data1, 4'h0);
    rst = 1'b0;
    repeat (10) tick();

    // Single write then read back.
    set_wr(0, 0, 4'h3, 4'hA);
    tick(); chk("t2 wr_gnt", s_wg[0], 4'h1);
    set_rd(0, 0, 4'h3);
    tick(); chk("t2 rd_gnt", s_rg[0], 4'h1);
    tick(); chk("t2 vld early", s_vl[0], 4'h0);
    tick(); chk("t2 rd_vld", s_vl[0], 4'h1); chk("t2 rd_data", s_rd[0], 4'hA);

    // Write contention with both requesters holding.
    rst = 1'b1; tick(); rst = 1'b0;
    hold = 1'b1;
    set_wr(0, 0, 4'h8, 4'h1); set_wr(0, 1, 4'h9, 4'h2);
    for (int k = 0; k < 6; k++) begin
      tick(); chk("t3 wr_gnt", s_wg[0], (k % 2 == 0) ? 4'h1 : 4'h2);
    end
    hold = 1'b0; clr_all();
    repeat (3) tick();

    // Same-cycle collision: forwarded on n2, raw old data on n3.
    set_wr(0, 1, 4'h5, 4'h2); set_wr(1, 1, 4'h5, 4'h2);
    repeat (3) tick();
    set_wr(0, 0, 4'h5, 4'h7); set_rd(0, 1, 4'h5);
    set_wr(1, 0, 4'h5, 4'h7); set_rd(1, 1, 4'h5);
    tick(); tick(); tick();
    chk("t4 fwd vld", s_vl[0], 4'h2); chk("t4 fwd data", s_rd[0], 4'h7);
    chk("t4 raw vld", s_vl[1], 4'h2); chk("t4 raw data", s_rd[1], 4'h2);
    repeat (2) tick();

    // Reset while a read is in flight.
    set_rd(0, 0, 4'h2);
    tick(); chk("t5 rd_gnt", s_rg[0], 4'h1);
    rst = 1'b1; tick(); rst = 1'b0;
    set_rd(0, 0, 4'h1); set_rd(0, 1, 4'h1);
    tick(); chk("t5 no vld", s_vl[0], 4'h0); chk("t5 first gnt", s_rg[0], 4'h1);
    repeat (4) tick();

    // Three-way read fairness with pointer wrap.
    hold = 1'b1;
    for (int i = 0; i < 3; i++) set_rd(1, i, 4'(i));
    for (int k = 0; k < 9; k++) begin
      tick(); chk("t6 rd_gnt", s_rg[1], 4'(1 << (k % 3)));
    end
    hold = 1'b0; clr_all();
    repeat (4) tick();

    // Randomized traffic with occasional resets and abandoned requests.
    repeat (1500) begin
      rst = ($urandom_range(0, 149) == 0);
      for (int d = 0; d < 2; d++) begin
        for (int i = 0; i < ((d == 0) ? 2 : 3); i++) begin
          if (!wq[d][i]) begin
            if ($urandom_range(0, 2) == 0)
              set_wr(d, i, 4'($urandom_range(0, 3)), 4'($urandom_range(0, 15)));
          end else if ($urandom_range(0, 19) == 0) wq[d][i] = 1'b0;
          if (!rq[d][i]) begin
            if ($urandom_range(0, 2) == 0) set_rd(d, i, 4'($urandom_range(0, 3)));
          end else if ($urandom_range(0, 19) == 0) rq[d][i] = 1'b0;
        end
      end
      tick();
    end
    rst = 1'b0; clr_all();
    repeat (4) tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
